stdp_array: RTL and testbench
=============================

Name: stdp_array

Overview:
- Parametrised pair-based STDP learning block for N_SYN synapses converging on one post-synaptic neuron.
- Per-synapse pre-spike timers and a shared post-spike timer feed a window check; LTP is applied on post spikes and LTD on pre spikes.
- Updates use a shift-decay magnitude and saturate to [0, W_MAX].
- Successor to the single-synapse LTP-only block; it drives the synaptic weight bus into the neuron/accumulator stage.

Parameters:
- N_SYN, 4, number of pre-synaptic inputs/weights
- WW, 8, weight width (unsigned)
- TW, 6, timer width; timers saturate at T_MAX = 2^TW-1
- WINDOW, 16, max timer value (exclusive) that still causes an update; must be <= T_MAX
- TAU_SHIFT, 2, decay step: magnitude halves every 2^TAU_SHIFT cycles
- A_PLUS, 32, LTP base magnitude (< 2^WW)
- A_MINUS, 16, LTD base magnitude (< 2^WW)
- W_MAX, 255, upper weight clamp (<= 2^WW-1)
- W_INIT, 64, weight reset value

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- pre_spike  in  N_SYN  pre-synaptic spikes, one bit per synapse, sampled each edge
- post_spike  in  1  post-synaptic spike
- learn_en  in  1  1 = apply STDP updates; 0 = weights frozen, timers still run
- wr_en  in  1  direct weight load strobe
- wr_addr  in  clog2(N_SYN)  synapse index for load
- wr_data  in  WW  load value, clamped to W_MAX
- weights  out  N_SYN*WW  flattened weights, synapse i at [i*WW +: WW], registered
- ltp_pulse  out  N_SYN  1-cycle flag: synapse i potentiated on the last edge
- ltd_pulse  out  N_SYN  1-cycle flag: synapse i depressed on the last edge

Behaviour:
- Reset (rst=1 at an edge): all weights = W_INIT; pre_t[i] and post_t = T_MAX ("no spike seen"); ltp_pulse and ltd_pulse = 0. Reset mid-operation discards all timing history; no update fires on the reset edge.
- Timers, per edge:
  - pre_t[i] <= pre_spike[i] ? 0 : sat_inc(pre_t[i]).
  - post_t <= post_spike ? 0 : sat_inc(post_t).
  - sat_inc holds at T_MAX with no wrap.
- Update evaluation uses timer values before the edge (old values) and the spike inputs at the edge.
- LTP, synapse i: post_spike=1 AND pre_spike[i]=0 AND pre_t[i] < WINDOW.
  - delta = A_PLUS >> (pre_t[i] >> TAU_SHIFT); shift >= WW gives 0.
  - new = min(w + delta, W_MAX), computed at WW+1 bits.
- LTD, synapse i: pre_spike[i]=1 AND post_spike=0 AND post_t < WINDOW.
  - delta = A_MINUS >> (post_t >> TAU_SHIFT).
  - new = (w < delta) ? 0 : w - delta.
- Simultaneous pre_spike[i] and post_spike: no update for i (dt=0); both timers still clear.
- LTP and LTD are mutually exclusive per synapse per edge. Different synapses update in parallel in the same edge.
- Latency: the weight change and its ltp/ltd_pulse are visible right after the spike edge (1 edge). Pulses last exactly one cycle.
- delta=0 after decay: weight unchanged, but the pulse still asserts because the window condition was met.
- learn_en=0: no weight change and no pulses; timers are unaffected.
- wr_en=1: weights[wr_addr] <= min(wr_data, W_MAX). The load overrides any learning update to the same synapse on that edge; other synapses learn normally. wr_addr >= N_SYN is ignored.
- Repeated post spikes: each one pairs with the current pre_t (nearest-neighbour). A pre timer is never consumed by a pairing.

Decomposition:
- stdp_pkg holds:
  - default parameter constants;
  - the shift-decay magnitude function (base, timer, TAU_SHIFT, WW);
  - the saturating add/sub functions.
- Sub-module stdp_timer: a TW-bit saturating counter with a clear input and a parametrised reset value. It is instantiated N_SYN+1 times.

Test Plan:
- Reset → weights all 64; pulses 0. Then idle 100 cycles → no change; timers saturate at 63.
- LTP: pre_spike[0] at edge 10, post_spike at edge 13 (pre_t=2) → w0 64→96 after edge 13, ltp_pulse=0001 for one cycle. Repeat with post at edge 16 (pre_t=5, delta 16) → +16.
- LTD: post at edge 20, pre_spike[2] at edge 29 (post_t=8, delta 4) → w2 64→60, ltd_pulse=0100. With pre at edge 37 (post_t=16, outside WINDOW) → no change, no pulse.
- Saturation: load w1=250, then LTP with delta 32 → 255. Load w3=5, then LTD with delta 16 → 0.
- Simultaneous/priority checks:
  - pre_spike[0] and post_spike on the same edge → no update.
  - wr_en to synapse 1 with wr_data=10 on an LTP edge → w1=10, while other synapses update.
- learn_en=0 during a valid pairing → weights frozen, no pulses. Assert rst between pre and post → no update after reset.

Source files
------------

// File: rtl/stdp_pkg.sv
// Shared constants and arithmetic helpers for the pair-based STDP array.
package stdp_pkg;

  localparam int N_SYN_DEF     = 4;
  localparam int WW_DEF        = 8;
  localparam int TW_DEF        = 6;
  localparam int WINDOW_DEF    = 16;
  localparam int TAU_SHIFT_DEF = 2;
  localparam int A_PLUS_DEF    = 32;
  localparam int A_MINUS_DEF   = 16;
  localparam int W_MAX_DEF     = 255;
  localparam int W_INIT_DEF    = 64;

  // Update magnitude halves every 2^tau_shift cycles of elapsed time.
  // Shifting by the full weight width or more leaves nothing, so return 0.
  function automatic int unsigned decay_mag(input int unsigned base,
                                            input int unsigned timer,
                                            input int unsigned tau_shift,
                                            input int unsigned ww);
    int unsigned sh;
    sh = timer >> tau_shift;
    if (sh >= ww) return 0;
    return base >> sh;
  endfunction

  // Add with an upper clamp; operands are small so 32 bits never overflow.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_val);
    int unsigned s;
    s = a + b;
    return (s > max_val) ? max_val : s;
  endfunction

  // Subtract with a floor at zero.
  function automatic int unsigned sat_sub(input int unsigned a,
                                          input int unsigned b);
    return (a < b) ? 0 : a - b;
  endfunction

endpackage

// File: rtl/stdp_timer.sv
// Saturating spike-age counter: cleared by a spike, counts up, holds at all-ones.
module stdp_timer #(
  parameter int            TW      = 6,
  parameter logic [TW-1:0] RST_VAL = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [TW-1:0] t
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: restart on a spike, otherwise age by one until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register; reset value marks "no spike seen".
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign t = cnt_q;

endmodule

// File: rtl/stdp_array.sv
// Pair-based STDP for N_SYN synapses onto one neuron: LTP on post spikes,
// LTD on pre spikes, shift-decayed magnitudes, weights clamped to [0, W_MAX].
module stdp_array
  import stdp_pkg::*;
#(
  parameter int N_SYN     = N_SYN_DEF,
  parameter int WW        = WW_DEF,
  parameter int TW        = TW_DEF,
  parameter int WINDOW    = WINDOW_DEF,
  parameter int TAU_SHIFT = TAU_SHIFT_DEF,
  parameter int A_PLUS    = A_PLUS_DEF,
  parameter int A_MINUS   = A_MINUS_DEF,
  parameter int W_MAX     = W_MAX_DEF,
  parameter int W_INIT    = W_INIT_DEF,
  localparam int AW       = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SYN-1:0]      pre_spike,
  input  logic                  post_spike,
  input  logic                  learn_en,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WW-1:0]         wr_data,
  output logic [N_SYN*WW-1:0]   weights,
  output logic [N_SYN-1:0]      ltp_pulse,
  output logic [N_SYN-1:0]      ltd_pulse
);

  localparam logic [TW-1:0] T_MAX   = '1;
  localparam logic [TW-1:0] WIN_T   = TW'(WINDOW);
  localparam logic [WW-1:0] W_MAX_W = WW'(W_MAX);

  logic [TW-1:0] post_t;

  // Shared age of the most recent post spike.
  stdp_timer #(.TW(TW), .RST_VAL(T_MAX)) u_post_timer (
    .clk (clk),
    .rst (rst),
    .clr (post_spike),
    .t   (post_t)
  );

  for (genvar gi = 0; gi < N_SYN; gi++) begin : g_syn
    logic [TW-1:0] pre_t;
    logic [WW-1:0] w_q, w_d;
    logic          ltp_q, ltp_d;
    logic          ltd_q, ltd_d;
    logic          wr_hit;

    // Age of this synapse's most recent pre spike.
    stdp_timer #(.TW(TW), .RST_VAL(T_MAX)) u_pre_timer (
      .clk (clk),
      .rst (rst),
      .clr (pre_spike[gi]),
      .t   (pre_t)
    );

    // Window checks on pre-edge timer values; a direct load wins over learning
    // and also suppresses the pulse since the learned value is discarded.
    always_comb begin
      wr_hit = wr_en && (wr_addr == AW'(gi));
      ltp_d  = learn_en && post_spike && !pre_spike[gi] && (pre_t < WIN_T) && !wr_hit;
      ltd_d  = learn_en && pre_spike[gi] && !post_spike && (post_t < WIN_T) && !wr_hit;
      w_d    = w_q;
      if (ltp_d)
        w_d = WW'(sat_add(32'(w_q), decay_mag(A_PLUS, 32'(pre_t), TAU_SHIFT, WW), W_MAX));
      if (ltd_d)
        w_d = WW'(sat_sub(32'(w_q), decay_mag(A_MINUS, 32'(post_t), TAU_SHIFT, WW)));
      if (wr_hit)
        w_d = (wr_data > W_MAX_W) ? W_MAX_W : wr_data;
    end

    // Weight and one-cycle pulse registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        w_q   <= WW'(W_INIT);
        ltp_q <= 1'b0;
        ltd_q <= 1'b0;
      end else begin
        w_q   <= w_d;
        ltp_q <= ltp_d;
        ltd_q <= ltd_d;
      end
    end

    assign weights[gi*WW +: WW] = w_q;
    assign ltp_pulse[gi]        = ltp_q;
    assign ltd_pulse[gi]        = ltd_q;
  end

endmodule

// File: tb/tb_stdp_array.sv
// Directed plus randomized bench for stdp_array against a behavioural model.
module tb_stdp_array;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pre_spike;
  logic        post_spike;
  logic        learn_en;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [31:0] weights;
  logic [3:0]  ltp_pulse;
  logic [3:0]  ltd_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_w[4];
  int m_pre[4];
  int m_post;
  logic [3:0] m_ltp, m_ltd;

  stdp_array dut (
    .clk        (clk),
    .rst        (rst),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .learn_en   (learn_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .weights    (weights),
    .ltp_pulse  (ltp_pulse),
    .ltd_pulse  (ltd_pulse)
  );

  always #5 clk = ~clk;

  function automatic int mag(input int base, input int t);
    int sh;
    sh = t / 4;
    if (sh >= 8) return 0;
    return base / (2 ** sh);
  endfunction

  function automatic logic [7:0] dut_w(input int i);
    return weights[i*8 +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    int nw;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_w[i] = 64; m_pre[i] = 63;
      end
      m_post = 63; m_ltp = '0; m_ltd = '0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      m_ltp[i] = learn_en && post_spike && !pre_spike[i] && (m_pre[i] < 16);
      m_ltd[i] = learn_en && pre_spike[i] && !post_spike && (m_post < 16);
      nw = m_w[i];
      if (m_ltp[i]) nw = (m_w[i] + mag(32, m_pre[i]) > 255) ? 255 : m_w[i] + mag(32, m_pre[i]);
      if (m_ltd[i]) nw = (m_w[i] - mag(16, m_post) < 0) ? 0 : m_w[i] - mag(16, m_post);
      if (wr_en && int'(wr_addr) == i) begin
        nw = (wr_data > 255) ? 255 : int'(wr_data);
        m_ltp[i] = 1'b0; m_ltd[i] = 1'b0;
      end
      m_w[i] = nw;
    end
    for (int i = 0; i < 4; i++)
      m_pre[i] = pre_spike[i] ? 0 : ((m_pre[i] < 63) ? m_pre[i] + 1 : 63);
    m_post = post_spike ? 0 : ((m_post < 63) ? m_post + 1 : 63);
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_w;
    for (int i = 0; i < 4; i++) exp_w[i*8 +: 8] = 8'(m_w[i]);
    check({tag, "_weights"}, weights, exp_w);
    check({tag, "_ltp"}, {28'd0, ltp_pulse}, {28'd0, m_ltp});
    check({tag, "_ltd"}, {28'd0, ltd_pulse}, {28'd0, m_ltd});
  endtask

  // One clock edge with the given spikes; one-shot strobes clear afterwards.
  task automatic step(input logic [3:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
    pre_spike  = '0;
    post_spike = 1'b0;
    wr_en      = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'b0000, 1'b0);
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    logic [7:0]  w_save;
    logic [31:0] all_save;
    logic [3:0]  rp;
    rst = 1'b1; pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 4; i++) begin m_w[i] = 0; m_pre[i] = 0; end
    m_post = 0; m_ltp = '0; m_ltd = '0;

    // Reset state
    step(4'b0000, 1'b0);
    check("reset_weights", weights, {4{8'd64}});
    check("reset_ltp", {28'd0, ltp_pulse}, 32'd0);
    check("reset_ltd", {28'd0, ltd_pulse}, 32'd0);
    idle(100);
    check("idle_weights", weights, {4{8'd64}});

    // LTP: pre_t=2 gives +32, then pre_t=5 gives +16
    step(4'b0001, 1'b0); idle(2); step(4'b0000, 1'b1);
    check("ltp_w0_96", {24'd0, dut_w(0)}, 32'd96);
    check("ltp_pulse0", {28'd0, ltp_pulse}, 32'h1);
    idle(1);
    check("ltp_pulse_1cyc", {28'd0, ltp_pulse}, 32'h0);
    idle(1); step(4'b0000, 1'b1);
    check("ltp_w0_112", {24'd0, dut_w(0)}, 32'd112);

    // LTD: post_t=8 gives -4; post_t=16 is outside the window
    step(4'b0000, 1'b1); idle(8); step(4'b0100, 1'b0);
    check("ltd_w2_60", {24'd0, dut_w(2)}, 32'd60);
    check("ltd_pulse2", {28'd0, ltd_pulse}, 32'h4);
    idle(7); step(4'b0100, 1'b0);
    check("ltd_outside_w2", {24'd0, dut_w(2)}, 32'd60);
    check("ltd_outside_pulse", {28'd0, ltd_pulse}, 32'h0);

    // Saturation at both ends
    idle(20);
    load(2'd1, 8'd250); step(4'b0000, 1'b0);
    check("load_w1", {24'd0, dut_w(1)}, 32'd250);
    step(4'b0010, 1'b0); idle(2); step(4'b0000, 1'b1);
    check("sat_high_w1", {24'd0, dut_w(1)}, 32'd255);
    load(2'd3, 8'd5); step(4'b0000, 1'b0);
    step(4'b0000, 1'b1); step(4'b1000, 1'b0);
    check("sat_low_w3", {24'd0, dut_w(3)}, 32'd0);
    check("sat_low_pulse", {28'd0, ltd_pulse}, 32'h8);

    // Simultaneous pre and post: no update for that synapse
    idle(20);
    step(4'b0001, 1'b0); idle(2);
    w_save = dut_w(0);
    step(4'b0001, 1'b1);
    check("simul_w0", {24'd0, dut_w(0)}, {24'd0, w_save});
    check("simul_ltp0", {31'd0, ltp_pulse[0]}, 32'd0);

    // Load overrides learning on the same synapse only
    idle(20);
    step(4'b0111, 1'b0); idle(1);
    load(2'd1, 8'd10); step(4'b0000, 1'b1);
    check("wr_override_w1", {24'd0, dut_w(1)}, 32'd10);
    check("wr_override_ltp", {28'd0, ltp_pulse}, 32'h5);

    // learn_en low freezes weights during a valid pairing
    idle(20);
    step(4'b0001, 1'b0); idle(1);
    all_save = weights;
    learn_en = 1'b0; step(4'b0000, 1'b1); learn_en = 1'b1;
    check("frozen_weights", weights, all_save);
    check("frozen_ltp", {28'd0, ltp_pulse}, 32'h0);

    // Reset between pre and post discards the history
    idle(20);
    step(4'b0001, 1'b0);
    rst = 1'b1; step(4'b0000, 1'b0);
    check("midrst_weights", weights, {4{8'd64}});
    step(4'b0000, 1'b1);
    check("midrst_no_ltp", {28'd0, ltp_pulse}, 32'h0);
    check("midrst_weights2", weights, {4{8'd64}});

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) rp[i] = ($urandom_range(0, 5) == 0);
      learn_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      step(rp, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
